fake_netlist_bist_driver: RTL and testbench

Self-test harness for the generated single-output combinational netlists. It drives a stimulus vector onto a netlist's primary inputs, on the other side of the netlist from its output. It compacts the netlist's single output into a multiple-input signature register (MISR). It then reports pass/fail against an expected signature. It sits beside each generated netlist instance as the driver and sampler of that netlist's pins.

---
 rtl/fake_netlist_bist_driver.sv | 63 ++++++
 tb/tb_fake_netlist_bist_driver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fake_netlist_bist_driver.sv
// fake_netlist_bist_driver: drives LFSR patterns (binary up-count when FAKE_BIST_EXHAUSTIVE_EN is defined) into a netlist, compacts dut_out into a MISR and flags pass against EXP_SIG
module fake_netlist_bist_driver #(
  parameter int NUM_IN = 5,
  parameter int PAT_COUNT = 32,
  parameter logic [NUM_IN-1:0] LFSR_SEED = 'h01,
  parameter logic [NUM_IN-1:0] LFSR_TAPS = 'h14,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] EXP_SIG = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [NUM_IN-1:0] dut_in,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       pat_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic last;
  logic [SIG_W-1:0] sig_n;
  logic [NUM_IN-1:0] first_pat, next_pat;
`ifdef FAKE_BIST_EXHAUSTIVE_EN
  assign first_pat = '0;
  assign next_pat = dut_in + NUM_IN'(1);
`else
  assign first_pat = LFSR_SEED == '0 ? NUM_IN'(1) : LFSR_SEED;
  assign next_pat = {dut_in[NUM_IN-2:0], ^(dut_in & LFSR_TAPS)};
`endif
  assign last = pat_idx == 16'(PAT_COUNT - 1);
  assign sig_n = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(dut_out);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : state);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_in <= '0;
      signature <= '0;
      pat_idx <= '0;
      pass <= 1'b0;
    end else if (state == RUN) begin
      signature <= sig_n;
      pat_idx <= pat_idx + 16'd1;
      dut_in <= last ? dut_in : next_pat;
      pass <= last && sig_n == EXP_SIG;
    end else if (start) begin
      signature <= '0;
      pat_idx <= '0;
      dut_in <= first_pat;
      pass <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fake_netlist_bist_driver.sv
// tb_fake_netlist_bist_driver: scoreboard bench for the BIST driver against a modelled netlist
module tb_fake_netlist_bist_driver;
  localparam int PC = 32;
  logic clk = 0, rst_n = 0, start = 0;
  logic [1:0] mode = 0;
  logic [4:0] dut_in, s_dut_in;
  logic dut_out, busy, done, pass, s_busy, s_done, s_pass;
  logic [15:0] signature, pat_idx, s_signature, s_pat_idx;
  int checks = 0, failures = 0;
  logic [4:0] exp_in_q[$];
  logic [15:0] exp_sig_q[$];
  logic [4:0] obs[PC];
  always #5 clk = ~clk;
  function automatic logic [4:0] m_first(logic [4:0] seed);
`ifdef FAKE_BIST_EXHAUSTIVE_EN
    return 5'd0;
`else
    return seed == 5'd0 ? 5'd1 : seed;
`endif
  endfunction
  function automatic logic [4:0] m_next(logic [4:0] p);
`ifdef FAKE_BIST_EXHAUSTIVE_EN
    return p + 5'd1;
`else
    return {p[3:0], p[4] ^ p[2]};
`endif
  endfunction
  function automatic logic m_net(logic [1:0] md, logic [4:0] p);
    return md == 2'd0 ? 1'b0 : md == 2'd1 ? 1'b1 : p[4] ^ p[1] ^ (p[0] & p[3]);
  endfunction
  function automatic logic [15:0] m_misr(logic [15:0] s, logic b);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, b};
  endfunction
  assign dut_out = m_net(mode, dut_in);
  fake_netlist_bist_driver u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .pat_idx(pat_idx)
  );
  fake_netlist_bist_driver #(.PAT_COUNT(2), .LFSR_SEED(5'h00)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(s_dut_in), .dut_out(1'b1),
    .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_signature), .pat_idx(s_pat_idx)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [1:0] md, input bit hold);
    logic [4:0] p;
    logic [15:0] s;
    int c;
    mode = md;
    exp_in_q.delete();
    exp_sig_q.delete();
    p = m_first(5'h01);
    s = 16'h0000;
    for (int i = 0; i < PC; i++) begin
      exp_in_q.push_back(p);
      exp_sig_q.push_back(s);
      s = m_misr(s, m_net(md, p));
      if (i < PC - 1) p = m_next(p);
    end
    start = 1;
    tick;
    if (!hold) start = 0;
    chk("done_clear", done, 0);
    c = 0;
    while (busy && c < PC + 4) begin
      if (exp_in_q.size() == 0) begin
        chk("run_len", c, PC);
        break;
      end
      obs[c] = dut_in;
      chk("dut_in", dut_in, exp_in_q.pop_front());
      chk("sig_run", signature, exp_sig_q.pop_front());
      chk("pat_idx_run", pat_idx, c);
      tick;
      c++;
    end
    start = 0;
    chk("busy_cycles", c, PC);
    chk("done", done, 1);
    chk("sig_final", signature, s);
    chk("pass", pass, s == 16'h0000);
    chk("pat_idx_final", pat_idx, PC);
    chk("dut_in_hold", dut_in, p);
    repeat (3) tick;
    chk("done_hold", done, 1);
    chk("sig_stable", signature, s);
  endtask
  initial begin
    int c, cnt;
    bit ok;
    repeat (2) tick;
    chk("rst_dut_in", dut_in, 0);
    chk("rst_sig", signature, 0);
    chk("rst_pat_idx", pat_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    rst_n = 1;
    tick;
    chk("idle_busy", busy, 0);
    start = 1;
    tick;
    start = 0;
    chk("small_first", s_dut_in, m_first(5'h00));
    chk("small_busy", s_busy, 1);
    tick;
    chk("small_sig1", s_signature, 16'h0001);
    chk("small_idx1", s_pat_idx, 1);
    tick;
    chk("small_done", s_done, 1);
    chk("small_busy_fall", s_busy, 0);
    chk("small_sig2", s_signature, 16'h0003);
    chk("small_pass", s_pass, 0);
    chk("small_idx2", s_pat_idx, 2);
    c = 0;
    while (!done && c < 50) begin
      tick;
      c++;
    end
    chk("first_done_wait", done, 1);
    run(2'd0, 0);
    run(2'd1, 0);
    run(2'd2, 0);
    cnt = 0;
    for (int i = 0; i < PC - 1; i++) begin
      ok = obs[i] != 5'd0;
      for (int j = 0; j < i; j++) if (obs[j] == obs[i]) ok = 0;
      cnt += int'(ok);
    end
`ifdef FAKE_BIST_EXHAUSTIVE_EN
    chk("exh_last", obs[PC-1], 5'd31);
`else
    chk("lfsr_distinct", cnt, 31);
    chk("lfsr_wrap", obs[PC-1], 5'h01);
`endif
    run(2'd2, 1);
    mode = 2'd2;
    start = 1;
    tick;
    start = 0;
    repeat (10) tick;
    chk("mid_idx", pat_idx, 10);
    rst_n = 0;
    tick;
    chk("mrst_dut_in", dut_in, 0);
    chk("mrst_sig", signature, 0);
    chk("mrst_pat_idx", pat_idx, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_pass", pass, 0);
    rst_n = 1;
    tick;
    run(2'd2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
